// File: rtl/shft_pkg.sv
// Shared types and constants for the one-bit-per-cycle shift sequencer.
// Optional rotate support is controlled by the SHFT_ROTATE_EN macro.
package shft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shft_state_t;

    localparam logic SHFT_RIGHT = 1'b0;
    localparam logic SHFT_LEFT  = 1'b1;

endpackage

// File: rtl/shft_step.sv
// Combinational single-position shifter; zero fill, or rotate fill when SHFT_ROTATE_EN is defined.
// Latency: 0 cycles (pure combinational). Backpressure: none.
module shft_step
    import shft_pkg::*;
#(
    parameter int N = 7
) (
    input  logic [N:0] d,
    input  logic       dir,
    input  logic       rot,
    output logic [N:0] q
);

    logic fill;

`ifdef SHFT_ROTATE_EN
    always_comb begin
        fill = 1'b0;
        if (rot) begin
            fill = (dir == SHFT_LEFT) ? d[N] : d[0];
        end
    end
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign fill       = 1'b0;
`endif

    always_comb begin
        q = d;
        if (dir == SHFT_LEFT) begin
            q = {d[N-1:0], fill};
        end else begin
            q = {fill, d[N:1]};
        end
    end

endmodule

// File: rtl/shft_sequencer.sv
// Shift sequencer: accepts a command, shifts one position per clock, presents result. Rotate via SHFT_ROTATE_EN.
// Latency: cmd_cnt cycles from accept to res_valid; res_valid holds until res_ready, cmd_ready only in IDLE.
module shft_sequencer
    import shft_pkg::*;
#(
    parameter int         N       = 7,
    parameter int         CNT_W   = 4,
    parameter logic [N:0] RST_VAL = 8'hAA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N:0]       cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_rot,
    output logic [N:0]       q,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready
);

    shft_state_t      state_q;
    logic [N:0]       q_q;
    logic [N:0]       step_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             rot_q;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             res_valid_q;

    shft_step #(.N(N)) u_step (
        .d   (q_q),
        .dir (dir_q),
        .rot (rot_q),
        .q   (step_d)
    );

    // Handshake outputs are registered alongside the state so they never depend on inputs combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= RST_VAL;
            cnt_q       <= '0;
            dir_q       <= SHFT_RIGHT;
            rot_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        q_q         <= cmd_data;
                        cnt_q       <= cmd_cnt;
                        dir_q       <= cmd_dir;
                        rot_q       <= cmd_rot;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_cnt == '0) begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    q_q   <= step_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign q         = q_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_shft_sequencer.sv
// Self-checking bench for shft_sequencer: directed cases plus random commands against an arithmetic model.
module tb_shft_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_dir;
    logic [3:0] cmd_cnt;
    logic       cmd_rot;
    logic [7:0] q;
    logic       busy;
    logic       res_valid;
    logic       res_ready;

    int errors = 0;
    int checks = 0;

`ifdef SHFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    shft_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_cnt   (cmd_cnt),
        .cmd_rot   (cmd_rot),
        .q         (q),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift/rotate result from plain integer arithmetic on the whole operand.
    function automatic logic [7:0] model(input logic [7:0] d, input logic dir, input int cnt, input logic rot);
        int v = int'(d);
        int k = cnt % 8;
        if (rot && ROT_EN) begin
            if (dir) return 8'(((v << k) | (v >> (8 - k))) & 255);
            else     return 8'(((v >> k) | (v << (8 - k))) & 255);
        end
        if (dir) return 8'((v << cnt) & 255);
        return 8'(v >> cnt);
    endfunction

    // Issue one command, measure latency, apply back-pressure, then handshake the result.
    task automatic run_cmd(input string tag, input logic [7:0] d, input logic dir,
                           input logic [3:0] cnt, input logic rot, input int hold);
        logic [7:0] exp;
        int elapsed;
        exp = model(d, dir, int'(cnt), rot);
        check({tag, " ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_cnt   = cnt;
        cmd_rot   = rot;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_cnt   = 4'($urandom);
        cmd_rot   = 1'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        elapsed = 0;
        while (!res_valid && elapsed < 40) begin
            @(posedge clk);
            #1;
            elapsed++;
        end
        check({tag, " latency"}, 32'(elapsed), 32'(cnt));
        check({tag, " q"}, 32'(q), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'($urandom);
            cmd_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check({tag, " hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, " hold_q"}, 32'(q), 32'(exp));
            check({tag, " hold_ready"}, 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, " hs_valid"}, 32'(res_valid), 32'd0);
        check({tag, " hs_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " hs_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_cnt   = '0;
        cmd_rot   = 1'b0;
        res_ready = 1'b0;

        // Reset state
        #3 rst_n = 1'b0;
        #2;
        check("rst q", 32'(q), 32'hAA);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst res_valid", 32'(res_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_cmd("right1", 8'hAA, 1'b0, 4'd1, 1'b0, 0);
        run_cmd("left3_bp", 8'h81, 1'b1, 4'd3, 1'b0, 5);
        run_cmd("cnt0", 8'h3C, 1'b0, 4'd0, 1'b0, 1);
        run_cmd("cnt15", 8'hFF, 1'b0, 4'd15, 1'b0, 0);
        run_cmd("rot_r1", 8'h81, 1'b0, 4'd1, 1'b1, 0);
        run_cmd("rot_r8", 8'h81, 1'b0, 4'd8, 1'b1, 0);
        run_cmd("rot_l1", 8'h81, 1'b1, 4'd1, 1'b1, 0);

        // Reset mid-SHIFT: count 6, assert after 4 shifts
        cmd_valid = 1'b1;
        cmd_data  = 8'h5A;
        cmd_dir   = 1'b1;
        cmd_cnt   = 4'd6;
        cmd_rot   = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid q", 32'(q), 32'hAA);
        check("mid cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid busy", 32'(busy), 32'd0);
        check("mid res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("mid no_result", 32'(res_valid), 32'd0);
            check("mid q_stays", 32'(q), 32'hAA);
        end

        // Random commands
        for (int n = 0; n < 25; n++) begin
            run_cmd("rand", 8'($urandom), 1'($urandom), 4'($urandom),
                    1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
